// File: rtl/fetch_pkg.sv
// Shared constants and the {pc, inst} entry type for the instruction fetch slice.
package fetch_pkg;
  localparam int unsigned     XLEN     = 32;
  localparam int unsigned     IMEM_AW  = 15;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid FIFO holding fetched {pc, inst} pairs; head is always entry[0],
// so the head outputs come straight from a register.
module fetch_skid_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   count
);
  fetch_entry_t entry [2];
  logic         wr_idx;

  // Slot for the incoming word once the simultaneous pop (if any) has shifted.
  always_comb begin
    wr_idx = (count == 2'd2) || ((count == 2'd1) && !pop);
    head   = entry[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) entry[i] <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      if (pop) entry[0] <= entry[1];
      if (push) entry[wr_idx] <= push_data;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch PC sequencer for the synchronous-read instruction memory, with a skid
// buffer absorbing the read latency and execute-stage redirects flushing it.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC,
  parameter int unsigned IMEM_AW  = fetch_pkg::IMEM_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_ir,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_inst
);
  import fetch_pkg::fetch_entry_t;

  logic [31:0]  fetch_pc;
  logic [31:0]  req_pc;
  logic         req_valid;
  logic [31:0]  redirect_base;
  logic         pop;
  logic         push;
  logic         issue;
  logic [2:0]   occupancy;
  logic [1:0]   fifo_count;
  logic         unused_redirect_lsbs;
  fetch_entry_t push_data;
  fetch_entry_t head;

  // Only issue when the word returning next cycle is guaranteed a FIFO slot.
  always_comb begin
    redirect_base        = {redirect_pc[31:2], 2'b00};
    unused_redirect_lsbs = ^redirect_pc[1:0];
    out_valid            = (fifo_count != 2'd0);
    pop                  = out_valid && out_ready;
    push                 = req_valid && !redirect_valid;
    occupancy            = {1'b0, fifo_count} + {2'b00, req_valid} - {2'b00, pop};
    issue                = (occupancy < 3'd2);
    imem_addr            = redirect_valid ? redirect_pc[IMEM_AW+1:2] : fetch_pc[IMEM_AW+1:2];
    push_data.pc         = req_pc;
    push_data.inst       = imem_ir;
    out_pc               = head.pc;
    out_inst             = head.inst;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc  <= RESET_PC;
      req_valid <= 1'b0;
      req_pc    <= '0;
    end else if (redirect_valid) begin
      req_valid <= 1'b1;
      req_pc    <= redirect_base;
      fetch_pc  <= redirect_base + 32'd4;
    end else if (issue) begin
      req_valid <= 1'b1;
      req_pc    <= fetch_pc;
      fetch_pc  <= fetch_pc + 32'd4;
    end else begin
      req_valid <= 1'b0;
    end
  end

  fetch_skid_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (fifo_count)
  );
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: scenario tasks plus a
// stream-level reference model of the expected PC sequence.
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [14:0] imem_addr;
  logic [31:0] imem_ir;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  int checks = 0;
  int errors = 0;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(15)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_ir        (imem_ir),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
  );

  always #5 clk = ~clk;

  // Memory word i holds 0x1000 + i; one-cycle synchronous read.
  always @(posedge clk) imem_ir <= 32'h0000_1000 + 32'(imem_addr);

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return 32'h0000_1000 + ((pc >> 2) & 32'h0000_7FFF);
  endfunction

  // Reference model: after reset or a redirect the accepted stream is start,
  // start+4, ...; output is valid from the second cycle after the start onward.
  int          since = 0;
  logic [31:0] exp_pc = '0;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      since  = 0;
      exp_pc = 32'h0000_0000;
    end else begin
      checks++;
      if (out_valid !== 1'(since >= 2)) begin
        errors++;
        $display("FAIL mon_valid t=%0t since=%0d got %b want %b", $time, since, out_valid, since >= 2);
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (out_pc !== exp_pc || out_inst !== word_of(exp_pc)) begin
          errors++;
          $display("FAIL mon_pop t=%0t got pc=%h inst=%h want pc=%h inst=%h",
                   $time, out_pc, out_inst, exp_pc, word_of(exp_pc));
        end
        exp_pc += 32'd4;
      end
      checks++;
      if (dut.push === 1'b1 && dut.fifo_count == 2'd2) begin
        errors++;
        $display("FAIL mon_overflow t=%0t got push at count 2 want no push", $time);
      end
      if (redirect_valid) begin
        since  = 1;
        exp_pc = redirect_pc & ~32'h3;
      end else if (since < 1000) begin
        since++;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b1; #1 rst_n = 1'b0;
    out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({out_valid, out_pc, out_inst} !== 65'd0 || imem_addr !== 15'h0) begin
      errors++;
      $display("FAIL reset_state got v=%b pc=%h inst=%h addr=%h want all 0", out_valid, out_pc, out_inst, imem_addr);
    end
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1; #1;
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 15'h0) begin
      errors++;
      $display("FAIL reset_cycle0 got v=%b addr=%h want v=0 addr=0", out_valid, imem_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 15'h1) begin
      errors++;
      $display("FAIL reset_cycle1 got v=%b addr=%h want v=0 addr=1", out_valid, imem_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'h1000) begin
      errors++;
      $display("FAIL reset_cycle2 got v=%b pc=%h inst=%h want v=1 pc=0 inst=1000", out_valid, out_pc, out_inst);
    end
  endtask

  task automatic test_stream();
    for (int i = 3; i <= 20; i++) begin
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * (i - 2)) || out_inst !== 32'(32'h1000 + i - 2)) begin
        errors++;
        $display("FAIL stream_%0d got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                 i, out_valid, out_pc, out_inst, 4 * (i - 2), 32'h1000 + i - 2);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] head_pc, head_inst;
    logic [14:0] addr0;
    @(negedge clk); out_ready = 1'b0; #1;
    head_pc = out_pc; head_inst = out_inst; addr0 = imem_addr;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== head_pc || out_inst !== head_inst || imem_addr !== addr0) begin
        errors++;
        $display("FAIL stall_hold_%0d got v=%b pc=%h inst=%h addr=%h want v=1 pc=%h inst=%h addr=%h",
                 k, out_valid, out_pc, out_inst, imem_addr, head_pc, head_inst, addr0);
      end
    end
    @(negedge clk); out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== head_pc + 32'(4 * k)) begin
        errors++;
        $display("FAIL stall_release_%0d got v=%b pc=%h want v=1 pc=%h", k, out_valid, out_pc, head_pc + 32'(4 * k));
      end
    end
  endtask

  task automatic test_redirect_full();
    @(negedge clk); out_ready = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h0000_0100; #1;
    checks++;
    if (imem_addr !== 15'h0040) begin
      errors++;
      $display("FAIL redir_addr got %h want 0040", imem_addr);
    end
    @(negedge clk); redirect_valid = 1'b0; out_ready = 1'b1; #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_bubble got v=%b want 0", out_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_inst !== 32'h1040) begin
      errors++;
      $display("FAIL redir_target got v=%b pc=%h inst=%h want v=1 pc=100 inst=1040", out_valid, out_pc, out_inst);
    end
    @(negedge clk); #1;
    checks++;
    if (out_pc !== 32'h104 || out_inst !== 32'h1041) begin
      errors++;
      $display("FAIL redir_next got pc=%h inst=%h want pc=104 inst=1041", out_pc, out_inst);
    end
  endtask

  task automatic test_double_redirect();
    @(negedge clk); out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; #1;
    checks++;
    if (imem_addr !== 15'h0080) begin
      errors++;
      $display("FAIL dbl_addr0 got %h want 0080", imem_addr);
    end
    @(negedge clk); redirect_pc = 32'h0000_0300; #1;
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 15'h00C0) begin
      errors++;
      $display("FAIL dbl_addr1 got v=%b addr=%h want v=0 addr=00c0", out_valid, imem_addr);
    end
    @(negedge clk); redirect_valid = 1'b0; out_ready = 1'b1; #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL dbl_bubble got v=%b want 0", out_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h300 || out_inst !== 32'h10C0) begin
      errors++;
      $display("FAIL dbl_target got v=%b pc=%h inst=%h want v=1 pc=300 inst=10c0", out_valid, out_pc, out_inst);
    end
    @(negedge clk); #1;
    checks++;
    if (out_pc !== 32'h304) begin
      errors++;
      $display("FAIL dbl_next got pc=%h want 304", out_pc);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h0001_FFFB; out_ready = 1'b1; #1;
    checks++;
    if (imem_addr !== 15'h7FFE) begin
      errors++;
      $display("FAIL wrap_addr0 got %h want 7ffe", imem_addr);
    end
    @(negedge clk); redirect_valid = 1'b0; #1;
    checks++;
    if (imem_addr !== 15'h7FFF) begin
      errors++;
      $display("FAIL wrap_addr1 got %h want 7fff", imem_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (imem_addr !== 15'h0000 || out_pc !== 32'h0001_FFF8 || out_inst !== 32'h8FFE) begin
      errors++;
      $display("FAIL wrap_addr2 got addr=%h pc=%h inst=%h want addr=0000 pc=0001fff8 inst=8ffe", imem_addr, out_pc, out_inst);
    end
    @(negedge clk); #1;
    checks++;
    if (out_pc !== 32'h0001_FFFC || out_inst !== 32'h8FFF) begin
      errors++;
      $display("FAIL wrap_pc0 got pc=%h inst=%h want pc=0001fffc inst=8fff", out_pc, out_inst);
    end
    @(negedge clk); #1;
    checks++;
    if (out_pc !== 32'h0002_0000 || out_inst !== 32'h1000) begin
      errors++;
      $display("FAIL wrap_pc1 got pc=%h inst=%h want pc=00020000 inst=1000", out_pc, out_inst);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    @(negedge clk); #3 rst_n = 1'b0; #1;
    checks++;
    if ({out_valid, out_pc, out_inst} !== 65'd0 || imem_addr !== 15'h0) begin
      errors++;
      $display("FAIL async_reset got v=%b pc=%h inst=%h addr=%h want all 0", out_valid, out_pc, out_inst, imem_addr);
    end
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 15'h0) begin
      errors++;
      $display("FAIL restart_cycle0 got v=%b addr=%h want v=0 addr=0", out_valid, imem_addr);
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'h1000) begin
      errors++;
      $display("FAIL restart_cycle2 got v=%b pc=%h inst=%h want v=1 pc=0 inst=1000", out_valid, out_pc, out_inst);
    end
  endtask

  task automatic test_random();
    logic        hold = 1'b0;
    logic [31:0] hold_pc = '0, hold_inst = '0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = $urandom & 32'h0001_FFFF;
      #1;
      if (redirect_valid) begin
        checks++;
        if (32'(imem_addr) !== ((redirect_pc >> 2) & 32'h7FFF)) begin
          errors++;
          $display("FAIL rand_redir_addr got %h want %h", imem_addr, (redirect_pc >> 2) & 32'h7FFF);
        end
      end
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== hold_pc || out_inst !== hold_inst) begin
          errors++;
          $display("FAIL rand_hold got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                   out_valid, out_pc, out_inst, hold_pc, hold_inst);
        end
      end
      hold      = out_valid && !out_ready && !redirect_valid;
      hold_pc   = out_pc;
      hold_inst = out_inst;
    end
    @(negedge clk); redirect_valid = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_double_redirect();
    test_wrap();
    test_async_reset();
    test_random();
    repeat (3) @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
